// File: rtl/tagged_memory.sv
// tagged_memory: word + tag store on a multiplexed address/data bus, with registered read data.
// An address phase latches waddr; later data phases and reads without a strobe use that address.
module tagged_memory #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 64,
    parameter int TAG_W  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] i_ad,
    input  logic [TAG_W-1:0]  i_tag,
    input  logic              i_astb,
    input  logic              i_atomic,
    input  logic              i_rd,
    input  logic              i_wr,
    output logic [DATA_W-1:0] o_data,
    output logic [TAG_W-1:0]  o_tag
);
    logic [DATA_W-1:0] mem    [2**ADDR_W];
    logic [TAG_W-1:0]  tagmem [2**ADDR_W] = '{default: '0};
    logic [ADDR_W-1:0] waddr;
    logic [ADDR_W-1:0] ea;
    logic              unused_atomic;
    assign unused_atomic = i_atomic;
    assign ea = i_astb ? i_ad[ADDR_W-1:0] : waddr;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            waddr  <= '0;
            o_data <= '0;
            o_tag  <= '0;
        end else begin
            if (i_astb) waddr <= i_ad[ADDR_W-1:0];
            if (i_rd) begin
                o_data <= mem[ea];
                o_tag  <= tagmem[ea];
            end
        end
    end
    // A strobed cycle carries an address, so it can never be a data phase.
    always_ff @(posedge clk) begin
        if (reset_n && i_wr && !i_astb) begin
            mem[waddr]    <= i_ad;
            tagmem[waddr] <= i_tag;
        end
    end
endmodule

// File: tb/tb_tagged_memory.sv
// tb_tagged_memory: directed and randomized checks of tagged_memory against a map-based model.
module tb_tagged_memory;
    localparam int AW = 20;
    localparam int DW = 64;
    localparam int TW = 8;
    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [DW-1:0] i_ad = '0;
    logic [TW-1:0] i_tag = '0;
    logic          i_astb = 1'b0;
    logic          i_atomic = 1'b0;
    logic          i_rd = 1'b0;
    logic          i_wr = 1'b0;
    logic [DW-1:0] o_data;
    logic [TW-1:0] o_tag;
    always #5 clk = ~clk;
    tagged_memory #(.ADDR_W(AW), .DATA_W(DW), .TAG_W(TW)) dut (
        .clk(clk), .reset_n(reset_n), .i_ad(i_ad), .i_tag(i_tag), .i_astb(i_astb),
        .i_atomic(i_atomic), .i_rd(i_rd), .i_wr(i_wr), .o_data(o_data), .o_tag(o_tag)
    );
    int            n_checks = 0;
    int            n_fail = 0;
    logic [DW-1:0] m_mem [int];
    logic [TW-1:0] m_tag [int];
    logic [AW-1:0] m_waddr = '0;
    logic [DW-1:0] m_data = '0;
    logic [TW-1:0] m_otag = '0;
    task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask
    task automatic poke(input int a, input logic [DW-1:0] d, input logic [TW-1:0] t);
        dut.mem[a] = d;
        dut.tagmem[a] = t;
        m_mem[a] = d;
        m_tag[a] = t;
    endtask
    function automatic logic [TW-1:0] tag_of(input int a);
        return m_tag.exists(a) ? m_tag[a] : '0;
    endfunction
    // One bus cycle: drive at the falling edge, predict, check just after the rising edge.
    task automatic step(input logic astb, input logic rd, input logic wr, input logic at,
                        input logic [DW-1:0] ad, input logic [TW-1:0] tag);
        int ea;
        @(negedge clk);
        i_astb = astb; i_rd = rd; i_wr = wr; i_atomic = at; i_ad = ad; i_tag = tag;
        ea = astb ? int'(ad[AW-1:0]) : int'(m_waddr);
        if (rd) begin
            m_data = m_mem.exists(ea) ? m_mem[ea] : 'x;
            m_otag = tag_of(ea);
        end
        if (wr && !astb) begin
            m_mem[int'(m_waddr)] = ad;
            m_tag[int'(m_waddr)] = tag;
        end
        if (astb) m_waddr = ad[AW-1:0];
        @(posedge clk);
        #1;
        check("o_data", o_data, m_data);
        check("o_tag", DW'(o_tag), DW'(m_otag));
        check("waddr", DW'(dut.waddr), DW'(m_waddr));
    endtask
    task automatic idle();
        @(negedge clk);
        i_astb = 0; i_rd = 0; i_wr = 0; i_atomic = 0;
    endtask
    function automatic int pool_addr();
        return $urandom_range(0, 1) ? int'($urandom_range(0, 15)) : (2**AW - 1 - int'($urandom_range(0, 15)));
    endfunction
    initial begin
        #2;
        check("reset o_data", o_data, '0);
        check("reset o_tag", DW'(o_tag), '0);
        check("reset waddr", DW'(dut.waddr), '0);
        check("tagmem init", DW'(dut.tagmem[100]), '0);
        for (int i = 0; i < 16; i++) begin
            poke(i, {$urandom, $urandom}, TW'($urandom));
            poke(2**AW - 1 - i, {$urandom, $urandom}, TW'($urandom));
        end
        @(negedge clk);
        reset_n = 1'b1;
        poke(5, 64'h0123456789abcdef, 8'h3c);
        step(1, 1, 0, 0, 64'd5, '0);
        check("bd read data", o_data, 64'h0123456789abcdef);
        step(1, 0, 0, 0, 64'hfffff, '0);
        step(0, 0, 1, 0, 64'hdeadbeefcafef00d, 8'h11);
        step(0, 1, 0, 0, '0, '0);
        check("top addr data", o_data, 64'hdeadbeefcafef00d);
        check("top addr tag", DW'(o_tag), 64'h11);
        step(0, 0, 0, 0, 64'h1234, '0);
        check("hold o_data", o_data, 64'hdeadbeefcafef00d);
        poke(7, 64'd1, 8'h07);
        step(1, 1, 0, 1, 64'd7, '0);
        step(0, 1, 1, 0, 64'd2, 8'h22);
        check("rmw old data", o_data, 64'd1);
        check("rmw new mem", dut.mem[7], 64'd2);
        check("rmw waddr", DW'(dut.waddr), 64'd7);
        poke(9, 64'haa, 8'h09);
        step(1, 0, 1, 0, 64'd9, 8'hff);
        check("astb+wr mem", dut.mem[9], 64'haa);
        check("astb+wr tag", DW'(dut.tagmem[9]), 64'h09);
        step(1, 0, 0, 0, 64'hffff_ffff_fff0_0003, '0);
        check("upper bits", DW'(dut.waddr), 64'd3);
        poke(11, 64'h55, 8'h5a);
        step(1, 1, 0, 0, 64'd11, '0);
        @(negedge clk);
        i_astb = 0; i_rd = 1; i_wr = 1; i_ad = 64'hbad; i_tag = 8'hbb;
        #2;
        reset_n = 1'b0;
        #1;
        check("async rst data", o_data, '0);
        check("async rst tag", DW'(o_tag), '0);
        check("async rst waddr", DW'(dut.waddr), '0);
        @(posedge clk);
        #1;
        check("rst mem11", dut.mem[11], 64'h55);
        check("rst mem0", dut.mem[0], m_mem[0]);
        check("rst ign data", o_data, '0);
        idle();
        reset_n = 1'b1;
        m_waddr = '0; m_data = '0; m_otag = '0;
        for (int n = 0; n < 400; n++) begin
            logic astb;
            astb = ($urandom_range(0, 2) == 0);
            step(astb, 1'($urandom), 1'($urandom), 1'($urandom),
                 astb ? {$urandom, 12'($urandom), AW'(pool_addr())} : {$urandom, $urandom},
                 TW'($urandom));
        end
        idle();
        for (int i = 0; i < 16; i++) begin
            check("final mem lo", dut.mem[i], m_mem[i]);
            check("final mem hi", dut.mem[2**AW - 1 - i], m_mem[2**AW - 1 - i]);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
